// File: rtl/tpu_out_drain.sv
// tpu_out_drain: captures a 4x4 accumulator tile, narrows and column-masks it,
// and streams one packed row per cycle into GBUFF_OUT with tile/matrix completion flags.
module tpu_out_drain #(
  parameter int DATA_SIZE = 8,
  parameter int ACC_W     = 20,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   acc_valid_i,
  output logic                   acc_ready_o,
  input  logic [16*ACC_W-1:0]    acc_data_i,
  input  logic [ADDR_W-1:0]      base_addr_i,
  input  logic [2:0]             rows_valid_i,
  input  logic [2:0]             cols_valid_i,
  input  logic                   last_tile_i,
  output logic                   wr_en_o,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic [4*DATA_SIZE-1:0] wr_data_o,
  output logic                   busy_o,
  output logic                   tile_done_o,
  output logic                   done_o
);
  typedef enum logic [1:0] {IDLE, WRITE, FIN} state_e;
  state_e                 state_q, state_d;
  logic [16*ACC_W-1:0]    acc_q;
  logic [ADDR_W-1:0]      base_q;
  logic [2:0]             rows_q, cols_q;
  logic                   last_q;
  logic [1:0]             row_q, row_d;
  logic                   acc_ready_q, acc_ready_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [4*DATA_SIZE-1:0] wr_data_q, wr_data_d;
  logic                   busy_q, busy_d;
  logic                   tile_done_q, tile_done_d;
  logic                   done_q, done_d;
  logic                   hs, cap;
  logic [2:0]             rows_in, cols_in, cols_s;
  logic [16*ACC_W-1:0]    acc_s;
  logic [ADDR_W-1:0]      base_s;
  logic                   last_s;
  assign hs      = acc_ready_q & acc_valid_i;
  assign rows_in = rows_valid_i > 3'd4 ? 3'd4 : rows_valid_i;
  assign cols_in = cols_valid_i > 3'd4 ? 3'd4 : cols_valid_i;
  // Row 0 leaves on the handshake edge, so IDLE reads the live inputs
  assign cap    = state_q == IDLE;
  assign acc_s  = cap ? acc_data_i : acc_q;
  assign base_s = cap ? base_addr_i : base_q;
  assign cols_s = cap ? cols_in : cols_q;
  assign last_s = cap ? last_tile_i : last_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  always_comb begin
    state_d = state_q == IDLE  ? (hs ? (rows_in == 3'd0 ? FIN : WRITE) : IDLE) :
              state_q == WRITE ? ({1'b0, row_q} + 3'd1 == rows_q ? FIN : WRITE) : IDLE;
    row_d   = state_q == WRITE ? row_q + 2'd1 : 2'd0;
  end
  always_comb begin
    acc_ready_d = state_d == IDLE;
    wr_en_d     = state_d == WRITE;
    busy_d      = state_d != IDLE;
    tile_done_d = state_d == FIN;
    done_d      = (tile_done_d & last_s) | (done_q & ~start_i);
    wr_addr_d   = wr_en_d ? base_s + ADDR_W'(row_d) : '0;
    wr_data_d   = '0;
    for (int c = 0; c < 4; c++)
      if (wr_en_d && c < int'(cols_s))
        wr_data_d[c*DATA_SIZE +: DATA_SIZE] = acc_s[(int'(row_d)*4+c)*ACC_W +: DATA_SIZE];
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      acc_q  <= '0;
      base_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      last_q <= 1'b0;
    end else if (hs) begin
      acc_q  <= acc_data_i;
      base_q <= base_addr_i;
      rows_q <= rows_in;
      cols_q <= cols_in;
      last_q <= last_tile_i;
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      acc_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      acc_ready_q <= acc_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      tile_done_q <= tile_done_d;
      done_q      <= done_d;
    end
  assign acc_ready_o = acc_ready_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;
  assign tile_done_o = tile_done_q;
  assign done_o      = done_q;
endmodule

// File: tb/tb_tpu_out_drain.sv
// tb_tpu_out_drain: table-driven and randomized checks of tpu_out_drain against
// a cycle-timeline model of the drain (rows+2 period, one packed row per cycle).
module tb_tpu_out_drain;
  localparam int D = 8, A = 20, W = 8;
  logic clk = 0, rst_n = 0, start = 0, valid = 0, last = 0;
  logic [16*A-1:0] acc = '0;
  logic [W-1:0] base = '0;
  logic [2:0] rows = '0, cols = '0;
  logic acc_ready, wr_en, busy, tile_done, done;
  logic [W-1:0] wr_addr;
  logic [4*D-1:0] wr_data;
  int n_vec = 0, n_bad = 0;
  bit exp_done = 0;

  tpu_out_drain #(.DATA_SIZE(D), .ACC_W(A), .ADDR_W(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .acc_valid_i(valid), .acc_ready_o(acc_ready),
    .acc_data_i(acc), .base_addr_i(base), .rows_valid_i(rows), .cols_valid_i(cols),
    .last_tile_i(last), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .tile_done_o(tile_done), .done_o(done));

  always #5 clk = ~clk;

  typedef struct {
    logic [16*A-1:0] acc;
    logic [7:0] base;
    logic [2:0] rows, cols;
    bit last;
    int sj;
    logic [31:0] row0, rowl;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16*A-1:0] grid();
    logic [16*A-1:0] g = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) g[(r*4+c)*A +: A] = A'(16*r + c);
    return g;
  endfunction

  function automatic logic [16*A-1:0] rnd_acc();
    logic [16*A-1:0] v = '0;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Element (r,c) reduced modulo 2^D, zero beyond the valid column count
  function automatic logic [31:0] pack(input logic [16*A-1:0] a, input int r, input int cc);
    logic [31:0] w = '0;
    for (int c = 0; c < 4; c++)
      if (c < cc) begin
        logic [16*A-1:0] s;
        s = (a >> ((r*4+c)*A)) & {{(15*A){1'b0}}, {A{1'b1}}};
        w = w | (32'(s % 256) << (8*c));
      end
    return w;
  endfunction

  task automatic sample(input string tag, input bit er, input bit ew, input logic [7:0] ea,
                        input logic [31:0] ed, input bit eb, input bit et);
    chk({tag, " rdy/wr/busy/tdone/done"}, {59'd0, acc_ready, wr_en, busy, tile_done, done},
        {59'd0, er, ew, eb, et, exp_done});
    if (ew) chk({tag, " addr/data"}, {24'd0, wr_addr, wr_data}, {24'd0, ea, ed});
  endtask

  // sj: start is high during the cycle ending at handshake edge + sj (-1 = never)
  task automatic tile(input string tag, input logic [16*A-1:0] a, input logic [7:0] b,
                      input logic [2:0] rv, input logic [2:0] cv, input bit lt, input int sj,
                      input bit hold, input bit chk_rows, input logic [31:0] r0, input logic [31:0] rl);
    int R = rv > 4 ? 4 : int'(rv);
    int C = cv > 4 ? 4 : int'(cv);
    int k = 0;
    while (!acc_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (!acc_ready) begin
      n_vec++; n_bad++;
      $display("FAIL %s ready timeout: got 0 expected 1", tag);
      return;
    end
    acc = a; base = b; rows = rv; cols = cv; last = lt; valid = 1; start = (sj == 0);
    @(posedge clk); #1;
    valid = hold;
    for (int j = 0; j <= R + 1; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      acc = rnd_acc(); base = 8'($urandom); rows = 3'($urandom); cols = 3'($urandom); last = 1'($urandom);
      exp_done = (j == R && lt) ? 1'b1 : (j == sj) ? 1'b0 : exp_done;
      sample($sformatf("%s j%0d", tag, j), j > R, j < R, b + 8'(j), pack(a, j, C), j <= R, j == R);
      if (chk_rows && j == 0 && R > 0) chk({tag, " row0"}, {32'd0, wr_data}, {32'd0, r0});
      if (chk_rows && j == R - 1) chk({tag, " rowlast"}, {32'd0, wr_data}, {32'd0, rl});
      start = (j + 1 == sj);
    end
    start = 0;
  endtask

  vec_t tbl[5];

  initial begin
    logic [16*A-1:0] t = grid();
    t[A-1:0] = 20'h12345;
    t[2*A-1:A] = 20'hFFFFF;
    tbl[0] = '{grid(), 8'h10, 3'd4, 3'd4, 1'b1, -1, 32'h03020100, 32'h33323130};
    tbl[1] = '{t,      8'h40, 3'd1, 3'd2, 1'b0,  0, 32'h0000FF45, 32'h0000FF45};
    tbl[2] = '{grid(), 8'hFE, 3'd4, 3'd4, 1'b0, -1, 32'h03020100, 32'h33323130};
    tbl[3] = '{grid(), 8'h77, 3'd0, 3'd4, 1'b1, -1, 32'h0, 32'h0};
    tbl[4] = '{grid(), 8'h80, 3'd7, 3'd6, 1'b0,  2, 32'h03020100, 32'h33323130};

    valid = 1; acc = grid(); rows = 3'd4; cols = 3'd4; last = 1;
    repeat (3) begin @(posedge clk); #1; sample("reset", 0, 0, 0, 0, 0, 0); end
    rst_n = 1; valid = 0;
    repeat (2) begin @(posedge clk); #1; sample("release", 1, 0, 0, 0, 0, 0); end

    for (int i = 0; i < 5; i++)
      tile($sformatf("tbl%0d", i), tbl[i].acc, tbl[i].base, tbl[i].rows, tbl[i].cols,
           tbl[i].last, tbl[i].sj, 0, 1, tbl[i].row0, tbl[i].rowl);

    tile("b2b_a", grid(), 8'h30, 3'd4, 3'd4, 1'b1, 4, 1, 1, 32'h03020100, 32'h33323130);
    tile("b2b_b", rnd_acc(), 8'h50, 3'd3, 3'd4, 1'b0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] rv = 3'($urandom_range(0, 7));
      int R = rv > 4 ? 4 : int'(rv);
      int sj = int'($urandom_range(0, 6)) - 1;
      if (sj > R) sj = -1;
      tile($sformatf("rnd%0d", i), rnd_acc(), 8'($urandom), rv, 3'($urandom_range(0, 7)),
           1'($urandom), sj, 1'($urandom), 0, 0, 0);
    end

    tile("pre_rst", rnd_acc(), 8'h05, 3'd2, 3'd4, 1'b1, -1, 0, 0, 0, 0);
    acc = grid(); base = 8'h20; rows = 3'd4; cols = 3'd4; last = 1; valid = 1;
    @(posedge clk); #1; valid = 0;
    sample("mid j0", 0, 1, 8'h20, 32'h03020100, 1, 0);
    @(posedge clk); #1;
    sample("mid j1", 0, 1, 8'h21, 32'h13121110, 1, 0);
    rst_n = 0; #1;
    exp_done = 0;
    sample("mid rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    sample("mid rst hold", 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    repeat (6) begin @(posedge clk); #1; sample("post rst", 1, 0, 0, 0, 0, 0); end
    tile("after_rst", grid(), 8'h60, 3'd4, 3'd3, 1'b1, -1, 0, 1, 32'h00020100, 32'h00323130);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tpu_out_drain.md
# tpu_out_drain

Output-drain stage of the TPU, directly downstream of the 4x4 systolic array and upstream of the output global buffer (GBUFF_OUT). It captures one finished 4x4 tile of PE accumulators, narrows each to DATA_SIZE bits, packs each tile row into one 4-element word, and writes the rows into the buffer on consecutive cycles. It reports per-tile completion and a sticky `done` for the whole matrix; this `done` is what the top-level `done` port reflects.

## Interface
- DATA_SIZE, 8: output element width in bits.
- ACC_W, 20: PE accumulator width in bits.
- ADDR_W, 8: GBUFF_OUT word address width.
- clk  in  1  clock; all flops on the rising edge.
- rst  in  1  reset, asynchronous and active-low (asserted when 0).
- start  in  1  new-matrix pulse; clears `done`.
- acc_valid  in  1  tile result is present on `acc_data`.
- acc_ready  out  1  block can capture a tile.
- acc_data  in  16*ACC_W  PE(r,c) accumulator at bits [(r*4+c)*ACC_W +: ACC_W].
- base_addr  in  ADDR_W  word address for tile row 0.
- rows_valid  in  3  number of tile rows to write, 0..4.
- cols_valid  in  3  number of valid columns, 0..4.
- last_tile  in  1  this tile completes the matrix.
- wr_en  out  1  GBUFF_OUT write strobe.
- wr_addr  out  ADDR_W  GBUFF_OUT word address.
- wr_data  out  4*DATA_SIZE  packed row; column c occupies [c*DATA_SIZE +: DATA_SIZE].
- busy  out  1  a tile is being drained.
- tile_done  out  1  one-cycle pulse after a tile's last write.
- done  out  1  sticky matrix-complete flag.

## Operation
- **States.**
  - IDLE: `acc_ready` = 1.
  - WRITE: emit one row per cycle.
  - FIN: one cycle; pulses `tile_done`.
  - Transitions: IDLE→WRITE on `acc_valid && acc_ready` with clamped rows ≥ 1. IDLE→FIN on the same handshake with rows == 0. WRITE→FIN after the last row. FIN→IDLE always.
- **Capture.** On the handshake, register all 16 accumulators, `base_addr`, `rows_valid`, `cols_valid` and `last_tile`.
  - `rows_valid` and `cols_valid` values above 4 are clamped to 4.
  - `acc_valid` while not ready is ignored; nothing is captured or queued.
- **Narrowing.** Each element is acc[DATA_SIZE-1:0], i.e. truncation modulo 2^DATA_SIZE. No saturation, no rounding.
- **Column masking.** Columns c ≥ cols_valid are written as 0.
- **Writes.** A row counter r runs 0..rows-1.
  - wr_addr = base_addr + r, modulo 2^ADDR_W (wraps 0xFF→0x00 at ADDR_W = 8).
  - wr_data = packed row r.
- **FIN.** `tile_done` = 1. If the captured `last_tile` = 1, `done` is set.
- **`done`.**
  - Cleared by `start`.
  - If `start` and a done-set occur in the same cycle, the set wins.
  - `start` has no other effect, and does not abort a drain.
- **`busy`.** Equals 1 in WRITE and FIN.

## Timing
- **Reset values.** All outputs are registered. While rst = 0: `acc_ready` = 0; `wr_en`, `wr_addr`, `wr_data`, `busy`, `tile_done`, `done` = 0. First cycle after release: state IDLE, `acc_ready` = 1.
- **Latency.** Handshake at edge N gives:
  - `acc_ready` = 0 from N;
  - first `wr_en` visible in the cycle after N;
  - row r written at edge N+1+r;
  - `tile_done` high in cycle N+rows+1;
  - `acc_ready` = 1 again in cycle N+rows+2.
- **Throughput.** Tile period is rows+2 cycles; a 4-row tile takes 6 cycles.
- **`wr_en`.** High for exactly `rows` consecutive cycles per tile, never in IDLE or FIN.
- **Zero rows.** rows_valid = 0: no writes; `tile_done` pulses in cycle N+1.
- **Reset mid-drain.** Rest of tile is discarded; no further writes. `done` is cleared, and the block returns to IDLE after release.
- **Captured data.** Changes on `acc_data` and the sideband inputs after the handshake have no effect on the tile being drained.

## Test plan
- **Reset.** Hold rst = 0 while driving `acc_valid` = 1 → all outputs 0 and no capture; after release `acc_ready` = 1 with no writes.
- **Full tile.** PE(r,c) = 16*r + c, base 0x10, rows 4, cols 4, last 1 → writes 0x10..0x13. Row 0 data = 0x03020100, row 3 = 0x33323130. `tile_done` and `done` set in cycle N+5; `acc_ready` back in N+6.
- **Truncation and masking.** PE(0,0) = 0x12345, PE(0,1) = 0xFFFFF, cols 2, rows 1 → single write with data 0x0000FF45.
- **Address wrap.** base 0xFE, rows 4 → addresses FE, FF, 00, 01; with last 0, `done` stays 0.
- **Back-to-back and ignore.** `acc_valid` held high → second tile captured exactly in cycle N+6; its data changed mid-drain is not taken until then. `start` pulsed in the same cycle `done` is set → `done` = 1. A later `start` → `done` = 0.
- **Reset mid-drain.** rst = 0 after the second write of a 4-row tile → no further `wr_en`, `done` = 0. A new tile after release drains normally.
